// File: rtl/bcd_seg_disp.sv
// Two-digit multiplexed 7-segment driver with frame capture, a dead cycle per slot and leading-zero blanking.
// Optional blink while the captured count reads 99: define DISP_BLINK_EN.
module bcd_seg_disp #(
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_TICKS = 64
) (
  input  logic       CLK,
  input  logic       RESET_B,
  input  logic [7:0] Q_IN,
  input  logic       CNT_99,
  output logic [6:0] SEG_B,
  output logic [1:0] DIG_B
);
  localparam int            PW      = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic          sel_q, sel_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          tick, capture, blink_off;
  logic [3:0]    nib;
  logic [1:0]    strobe;

  // Segment order gfedcba on [6:0], 0 = lit; non-BCD nibbles show a dash.
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0:    dec = 7'b1000000;
      4'd1:    dec = 7'b1111001;
      4'd2:    dec = 7'b0100100;
      4'd3:    dec = 7'b0110000;
      4'd4:    dec = 7'b0011001;
      4'd5:    dec = 7'b0010010;
      4'd6:    dec = 7'b0000010;
      4'd7:    dec = 7'b1111000;
      4'd8:    dec = 7'b0000000;
      4'd9:    dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction

  always_comb begin
    tick      = (pre_cnt_q == PRE_MAX);
    capture   = tick & sel_q;
    pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    sel_d     = sel_q ^ tick;
    shadow_d  = capture ? Q_IN : shadow_q;
    // Decode from next-state values so the units slot shows the sample taken on this same edge.
    nib       = sel_d ? shadow_d[7:4] : shadow_d[3:0];
    seg_d     = seg_q;
    if (tick) seg_d = (sel_d && nib == 4'd0) ? 7'h7F : dec(nib);
    strobe    = sel_q ? ((shadow_q[7:4] == 4'd0) ? 2'b11 : 2'b01) : 2'b10;
    dig_d     = (tick || blink_off) ? 2'b11 : strobe;
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      pre_cnt_q <= '0;
      sel_q     <= 1'b1;
      shadow_q  <= 8'h00;
      seg_q     <= 7'h7F;
      dig_q     <= 2'b11;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      sel_q     <= sel_d;
      shadow_q  <= shadow_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  assign SEG_B = seg_q;
  assign DIG_B = dig_q;

`ifdef DISP_BLINK_EN
  localparam int            BW        = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  logic          shadow_99_q, shadow_99_d;
  logic          blink_on_q, blink_on_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;

  always_comb begin
    shadow_99_d = capture ? CNT_99 : shadow_99_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (!shadow_99_q) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (tick) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      shadow_99_q <= 1'b0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
    end else begin
      shadow_99_q <= shadow_99_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  assign blink_off = shadow_99_q & ~blink_on_q;
`else
  localparam int unused_blink_ticks = BLINK_TICKS;
  logic unused_cnt_99;
  assign unused_cnt_99 = CNT_99;
  assign blink_off     = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_seg_disp.sv
// Directed bench for bcd_seg_disp with SCAN_DIV = 4, BLINK_TICKS = 2.
module tb_bcd_seg_disp;
  logic       CLK;
  logic       RESET_B;
  logic [7:0] Q_IN;
  logic       CNT_99;
  logic [6:0] SEG_B;
  logic [1:0] DIG_B;

  int n_tests = 0;
  int n_fail  = 0;
  int ecnt    = 0;

  bcd_seg_disp #(.SCAN_DIV(4), .BLINK_TICKS(2)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .Q_IN(Q_IN), .CNT_99(CNT_99),
    .SEG_B(SEG_B), .DIG_B(DIG_B)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] q;
    logic [6:0] seg_u;
    logic [6:0] seg_t;
    logic [1:0] dig_t;
  } vec_t;

  localparam logic [6:0] BLANK = 7'b1111111;

  task automatic cyc();
    @(posedge CLK);
    #1;
    ecnt++;
  endtask

  // Edge number mod 8: 4 = units capture tick, 0 = tens tick.
  task automatic align_to(input int r);
    while ((ecnt % 8) != r) cyc();
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  task automatic release_reset();
    RESET_B = 1'b1;
    ecnt    = 0;
  endtask

  vec_t vecs[8];
  logic [1:0] blink_exp[6];

  initial begin
    vecs[0] = '{q: 8'h37, seg_u: 7'b1111000, seg_t: 7'b0110000, dig_t: 2'b01};
    vecs[1] = '{q: 8'h05, seg_u: 7'b0010010, seg_t: BLANK,      dig_t: 2'b11};
    vecs[2] = '{q: 8'hA3, seg_u: 7'b0110000, seg_t: 7'b0111111, dig_t: 2'b01};
    vecs[3] = '{q: 8'h00, seg_u: 7'b1000000, seg_t: BLANK,      dig_t: 2'b11};
    vecs[4] = '{q: 8'h9F, seg_u: 7'b0111111, seg_t: 7'b0010000, dig_t: 2'b01};
    vecs[5] = '{q: 8'h64, seg_u: 7'b0011001, seg_t: 7'b0000010, dig_t: 2'b01};
    vecs[6] = '{q: 8'h81, seg_u: 7'b1111001, seg_t: 7'b0000000, dig_t: 2'b01};
    vecs[7] = '{q: 8'h52, seg_u: 7'b0100100, seg_t: 7'b0010010, dig_t: 2'b01};

    RESET_B = 1'b0;
    Q_IN    = 8'h37;
    CNT_99  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_seg", {1'b0, SEG_B}, {1'b0, BLANK});
    check("reset_dig", {6'd0, DIG_B}, 8'd3);
    release_reset();

    // First frame after reset.
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("pre_tick_seg", {1'b0, SEG_B}, {1'b0, BLANK});
      check("pre_tick_dig", {6'd0, DIG_B}, 8'd3);
    end
    cyc();
    check("first_dead_dig", {6'd0, DIG_B}, 8'd3);
    check("first_units_seg", {1'b0, SEG_B}, {1'b0, 7'b1111000});
    cyc();
    check("first_units_dig", {6'd0, DIG_B}, 8'd2);
    align_to(0);
    check("first_tens_seg", {1'b0, SEG_B}, {1'b0, 7'b0110000});
    check("first_tens_dead", {6'd0, DIG_B}, 8'd3);
    cyc();
    check("first_tens_dig", {6'd0, DIG_B}, 8'd1);

    // Table of frames: value set just before the capture edge.
    for (int i = 0; i < 8; i++) begin
      align_to(3);
      Q_IN = vecs[i].q;
      cyc();
      check("vec_units_dead", {6'd0, DIG_B}, 8'd3);
      check("vec_units_seg", {1'b0, SEG_B}, {1'b0, vecs[i].seg_u});
      cyc();
      check("vec_units_dig", {6'd0, DIG_B}, 8'd2);
      Q_IN = 8'h88;
      align_to(0);
      check("vec_tens_seg", {1'b0, SEG_B}, {1'b0, vecs[i].seg_t});
      check("vec_tens_dead", {6'd0, DIG_B}, 8'd3);
      cyc();
      check("vec_tens_dig", {6'd0, DIG_B}, {6'd0, vecs[i].dig_t});
      cyc();
      check("vec_tens_seg_hold", {1'b0, SEG_B}, {1'b0, vecs[i].seg_t});
    end

    // Tear-free capture: change mid tens slot.
    align_to(3);
    Q_IN = 8'h12;
    cyc();
    check("tear_units2", {1'b0, SEG_B}, {1'b0, 7'b0100100});
    align_to(1);
    Q_IN = 8'h98;
    cyc();
    check("tear_tens_still1", {1'b0, SEG_B}, {1'b0, 7'b1111001});
    check("tear_tens_dig", {6'd0, DIG_B}, 8'd1);
    align_to(3);
    check("tear_tens_end", {1'b0, SEG_B}, {1'b0, 7'b1111001});
    cyc();
    check("tear_units8", {1'b0, SEG_B}, {1'b0, 7'b0000000});
    align_to(0);
    check("tear_tens9", {1'b0, SEG_B}, {1'b0, 7'b0010000});

    // Blink at 99; CNT_99 dropped during the second off slot.
`ifdef DISP_BLINK_EN
    blink_exp[0] = 2'b10; blink_exp[1] = 2'b01; blink_exp[2] = 2'b11;
    blink_exp[3] = 2'b11; blink_exp[4] = 2'b10; blink_exp[5] = 2'b01;
`else
    blink_exp[0] = 2'b10; blink_exp[1] = 2'b01; blink_exp[2] = 2'b10;
    blink_exp[3] = 2'b01; blink_exp[4] = 2'b10; blink_exp[5] = 2'b01;
`endif
    align_to(3);
    Q_IN   = 8'h99;
    CNT_99 = 1'b1;
    for (int s = 0; s < 6; s++) begin
      align_to((s % 2 == 0) ? 5 : 1);
      check("blink_slot_dig", {6'd0, DIG_B}, {6'd0, blink_exp[s]});
      if (s == 3) CNT_99 = 1'b0;
    end
    align_to(5);
    check("blink_resume_units", {6'd0, DIG_B}, 8'd2);
    align_to(1);
    check("blink_resume_tens", {6'd0, DIG_B}, 8'd1);

    // Async reset mid-slot at pre_cnt == 2 (units slot strobed).
    Q_IN = 8'h37;
    align_to(3);
    cyc();
    align_to(6);
    check("pre_reset_dig", {6'd0, DIG_B}, 8'd2);
    RESET_B = 1'b0;
    #1;
    check("async_reset_seg", {1'b0, SEG_B}, {1'b0, BLANK});
    check("async_reset_dig", {6'd0, DIG_B}, 8'd3);
    #3;
    release_reset();
    repeat (3) cyc();
    check("restart_pre_tick_dig", {6'd0, DIG_B}, 8'd3);
    cyc();
    check("restart_units_seg", {1'b0, SEG_B}, {1'b0, 7'b1111000});
    cyc();
    check("restart_units_dig", {6'd0, DIG_B}, 8'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
